// File: rtl/decode_stage_pkg.sv
// Shared widths, instruction layout, opcode encodings and decode-class helpers
// for the decode stage and its register file.
package decode_stage_pkg;

  localparam int WORD   = 32;
  localparam int ADDR   = 32;
  localparam int W_RD   = 4;
  localparam int W_OPC  = 4;
  localparam int W_DOPC = 10;
  localparam int W_CC   = 4;
  localparam int W_IMM  = 15;
  localparam int NREG   = 2 ** W_RD;

  // The packed struct fixes every field position: opc[31:28] rd[27:24]
  // rs[23:20] cc[19:16] imm_flag[15] imm[14:0].
  typedef struct packed {
    logic [W_OPC-1:0] opc;
    logic [W_RD-1:0]  rd;
    logic [W_RD-1:0]  rs;
    logic [W_CC-1:0]  cc;
    logic             imm_flag;
    logic [W_IMM-1:0] imm;
  } inst_t;

  typedef enum logic [W_OPC-1:0] {
    OPC_ADD   = 4'd0,
    OPC_SUB   = 4'd1,
    OPC_MUL   = 4'd2,
    OPC_DIV   = 4'd3,
    OPC_ABS   = 4'd4,
    OPC_SHL   = 4'd5,
    OPC_SHR   = 4'd6,
    OPC_AND   = 4'd7,
    OPC_OR    = 4'd8,
    OPC_XOR   = 4'd9,
    OPC_SET   = 4'd10,
    OPC_LOAD  = 4'd11,
    OPC_STORE = 4'd12,
    OPC_BR    = 4'd13
  } opc_e;

  // One-hot class bit positions on dopc.
  localparam int D_ADDSUB = 0;
  localparam int D_MUL    = 1;
  localparam int D_DIV    = 2;
  localparam int D_ABS    = 3;
  localparam int D_SHIFT  = 4;
  localparam int D_LOGIC  = 5;
  localparam int D_SET    = 6;
  localparam int D_LOAD   = 7;
  localparam int D_STORE  = 8;
  localparam int D_BRANCH = 9;

  // Classes that produce a register result.
  localparam logic [W_DOPC-1:0] WB_MASK = 10'h0FF;

  function automatic logic [W_DOPC-1:0] dopc_of(input logic [W_OPC-1:0] opc);
    logic [W_DOPC-1:0] d;
    d = '0;
    case (opc)
      OPC_ADD, OPC_SUB:         d[D_ADDSUB] = 1'b1;
      OPC_MUL:                  d[D_MUL]    = 1'b1;
      OPC_DIV:                  d[D_DIV]    = 1'b1;
      OPC_ABS:                  d[D_ABS]    = 1'b1;
      OPC_SHL, OPC_SHR:         d[D_SHIFT]  = 1'b1;
      OPC_AND, OPC_OR, OPC_XOR: d[D_LOGIC]  = 1'b1;
      OPC_SET:                  d[D_SET]    = 1'b1;
      OPC_LOAD:                 d[D_LOAD]   = 1'b1;
      OPC_STORE:                d[D_STORE]  = 1'b1;
      OPC_BR:                   d[D_BRANCH] = 1'b1;
      default:                  d = '0;
    endcase
    return d;
  endfunction

  function automatic logic writes_back(input logic [W_DOPC-1:0] dopc);
    return |(dopc & WB_MASK);
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Register file: 2^W_RD x WORD, two async read ports, one sync write port.
// With WB_BYPASS_EN defined, port A and B reads forward same-cycle write data.
module decode_stage_regfile
  import decode_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [W_RD-1:0] ra_name,
  output logic [WORD-1:0] ra_data,
  input  logic [W_RD-1:0] rb_name,
  output logic [WORD-1:0] rb_data,
  input  logic            we,
  input  logic [W_RD-1:0] wr_name,
  input  logic [WORD-1:0] wr_data
);

  logic [WORD-1:0] mem [NREG];

  // NOTE: the array is reset like ordinary flops because software relies on
  // every register reading zero after reset; this blocks RAM-macro mapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_name] <= wr_data;
    end
  end

`ifdef WB_BYPASS_EN
  assign ra_data = (we && wr_name == ra_name) ? wr_data : mem[ra_name];
  assign rb_data = (we && wr_name == rb_name) ? wr_data : mem[rb_name];
`else
  assign ra_data = mem[ra_name];
  assign rb_data = mem[rb_name];
`endif

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field decode, register read, load-use interlock and issue
// registers toward EX. Optional macro WB_BYPASS_EN enables write-through reads.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  input  logic [WORD-1:0]   inst_i,
  input  logic [ADDR-1:0]   addr_i,
  output logic              stall_o,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic              wb_i,
  input  logic [W_RD-1:0]   wb_rd_name_i,
  input  logic [WORD-1:0]   wb_rd_data_i,
  output logic              v_o,
  output logic [WORD-1:0]   src_o,
  output logic [WORD-1:0]   dest_o,
  output logic              wb_o,
  output logic [W_RD-1:0]   wb_rd_name_o,
  output logic [W_DOPC-1:0] dopc_o,
  output logic [W_OPC-1:0]  opc_o,
  output logic [ADDR-1:0]   origaddr_o,
  output logic [W_CC-1:0]   cc_o
);

  inst_t             inst;
  logic [WORD-1:0]   rs_data, rd_data, src_next;
  logic [W_DOPC-1:0] dopc_next;
  logic              wb_next, ex_hit, wb_hit, interlock;

  assign inst = inst_t'(inst_i);

  decode_stage_regfile regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_name (inst.rs),
    .ra_data (rs_data),
    .rb_name (inst.rd),
    .rb_data (rd_data),
    .we      (wb_i),
    .wr_name (wb_rd_name_i),
    .wr_data (wb_rd_data_i)
  );

  assign src_next  = inst.imm_flag ? {{(WORD-W_IMM){inst.imm[W_IMM-1]}}, inst.imm}
                                   : rs_data;
  assign dopc_next = dopc_of(inst.opc);
  assign wb_next   = v_i & writes_back(dopc_next);

  // rd is always read (it feeds dest); rs only when no immediate replaces it.
  assign ex_hit = v_o & wb_o &
                  (((wb_rd_name_o == inst.rs) & ~inst.imm_flag) | (wb_rd_name_o == inst.rd));
`ifdef WB_BYPASS_EN
  assign wb_hit = 1'b0;
`else
  assign wb_hit = wb_i &
                  (((wb_rd_name_i == inst.rs) & ~inst.imm_flag) | (wb_rd_name_i == inst.rd));
`endif

  // A taken branch discards the IF instruction, so it never needs holding.
  assign interlock = v_i & (ex_hit | wb_hit) & ~branch_i;
  assign stall_o   = rst & (stall_i | interlock);

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_o          <= 1'b0;
      wb_o         <= 1'b0;
      src_o        <= '0;
      dest_o       <= '0;
      wb_rd_name_o <= '0;
      dopc_o       <= '0;
      opc_o        <= '0;
      origaddr_o   <= '0;
      cc_o         <= '0;
    end else if (!stall_i) begin
      if (branch_i || interlock) begin
        v_o  <= 1'b0;
        wb_o <= 1'b0;
      end else begin
        v_o          <= v_i;
        wb_o         <= wb_next;
        src_o        <= src_next;
        dest_o       <= rd_data;
        wb_rd_name_o <= inst.rd;
        dopc_o       <= dopc_next;
        opc_o        <= inst.opc;
        origaddr_o   <= addr_i;
        cc_o         <= inst.cc;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expectations are hand-derived
// per scenario. Honours WB_BYPASS_EN for the same-cycle writeback scenario.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v_i = 1'b0;
  logic [31:0] inst_i = '0;
  logic [31:0] addr_i = '0;
  logic        stall_o;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic        wb_i = 1'b0;
  logic [3:0]  wb_rd_name_i = '0;
  logic [31:0] wb_rd_data_i = '0;
  logic        v_o;
  logic [31:0] src_o, dest_o;
  logic        wb_o;
  logic [3:0]  wb_rd_name_o;
  logic [9:0]  dopc_o;
  logic [3:0]  opc_o;
  logic [31:0] origaddr_o;
  logic [3:0]  cc_o;

  int passed = 0;
  int total  = 0;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, AND = 4'd7, OR = 4'd8;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk          (clk),
    .rst          (rst),
    .v_i          (v_i),
    .inst_i       (inst_i),
    .addr_i       (addr_i),
    .stall_o      (stall_o),
    .stall_i      (stall_i),
    .branch_i     (branch_i),
    .wb_i         (wb_i),
    .wb_rd_name_i (wb_rd_name_i),
    .wb_rd_data_i (wb_rd_data_i),
    .v_o          (v_o),
    .src_o        (src_o),
    .dest_o       (dest_o),
    .wb_o         (wb_o),
    .wb_rd_name_o (wb_rd_name_o),
    .dopc_o       (dopc_o),
    .opc_o        (opc_o),
    .origaddr_o   (origaddr_o),
    .cc_o         (cc_o)
  );

  function automatic logic [31:0] enc(input logic [3:0] opc, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [3:0] cc,
                                      input logic immf, input logic [14:0] imm);
    return {opc, rd, rs, cc, immf, imm};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    v_i = 1'b0; wb_i = 1'b0; stall_i = 1'b0; branch_i = 1'b0;
  endtask

  task automatic write_reg(input logic [3:0] name, input logic [31:0] data);
    wb_i = 1'b1; wb_rd_name_i = name; wb_rd_data_i = data;
    tick();
    wb_i = 1'b0;
  endtask

  task automatic test_reset;
    stall_i = 1'b1; v_i = 1'b1; inst_i = enc(ADD, 4'd1, 4'd2, 4'd0, 1'b0, '0);
    #2;
    total++;
    if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o);
    else passed++;
    tick(); tick();
    total++;
    if ({v_o, wb_o, src_o, dest_o, wb_rd_name_o, dopc_o, opc_o, origaddr_o, cc_o} !== '0)
      $display("FAIL reset_outputs: v=%b wb=%b src=%h dest=%h dopc=%h", v_o, wb_o, src_o, dest_o, dopc_o);
    else passed++;
    idle();
    rst = 1'b1;
    #1;
    total++;
    if ({stall_o, v_o} !== 2'b00) $display("FAIL reset_release: got %b want 00", {stall_o, v_o});
    else passed++;
  endtask

  task automatic test_add;
    v_i = 1'b1; inst_i = enc(ADD, 4'd1, 4'd2, 4'hA, 1'b0, '0); addr_i = 32'h100;
    #1;
    total++;
    if (stall_o !== 1'b0) $display("FAIL add_stall: got %b want 0", stall_o);
    else passed++;
    tick();
    total++;
    if ({v_o, wb_o, wb_rd_name_o, dopc_o} !== {1'b1, 1'b1, 4'd1, 10'h001})
      $display("FAIL add_ctrl: got %b/%b/%0d/%h want 1/1/1/001", v_o, wb_o, wb_rd_name_o, dopc_o);
    else passed++;
    total++;
    if ({src_o, dest_o} !== {32'd5, 32'd3})
      $display("FAIL add_data: got src=%h dest=%h want 5/3", src_o, dest_o);
    else passed++;
    total++;
    if ({opc_o, cc_o, origaddr_o} !== {4'd0, 4'hA, 32'h100})
      $display("FAIL add_fields: got opc=%h cc=%h addr=%h want 0/a/100", opc_o, cc_o, origaddr_o);
    else passed++;
    v_i = 1'b0;
    tick();
    total++;
    if ({v_o, wb_o} !== 2'b00) $display("FAIL add_idle: got %b want 00", {v_o, wb_o});
    else passed++;
  endtask

  task automatic test_classes;
    logic [3:0] t_opc  [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    logic [9:0] t_dopc [12] = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020,
                               10'h040, 10'h080, 10'h100, 10'h200, 10'h000, 10'h000};
    logic       t_wb   [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      v_i = 1'b1; inst_i = enc(t_opc[i], 4'd10, 4'd11, 4'd0, 1'b0, '0);
      tick();
      total++;
      if ({v_o, wb_o, dopc_o, opc_o} !== {1'b1, t_wb[i], t_dopc[i], t_opc[i]})
        $display("FAIL class_%0d: got v=%b wb=%b dopc=%h want 1/%b/%h", t_opc[i], v_o, wb_o, dopc_o, t_wb[i], t_dopc[i]);
      else passed++;
      v_i = 1'b0;
      tick();
    end
  endtask

  task automatic test_imm;
    v_i = 1'b1; inst_i = enc(AND, 4'd2, 4'd0, 4'd0, 1'b1, 15'h7FFD);
    tick();
    total++;
    if ({src_o, dest_o, dopc_o} !== {32'hFFFF_FFFD, 32'd5, 10'h020})
      $display("FAIL imm_neg: got src=%h dest=%h dopc=%h want fffffffd/5/020", src_o, dest_o, dopc_o);
    else passed++;
    v_i = 1'b0; tick();
    v_i = 1'b1; inst_i = enc(OR, 4'd1, 4'd2, 4'd0, 1'b1, 15'h0123);
    tick();
    total++;
    if ({src_o, dest_o} !== {32'h0000_0123, 32'd3})
      $display("FAIL imm_pos: got src=%h dest=%h want 123/3", src_o, dest_o);
    else passed++;
    v_i = 1'b0; tick();
  endtask

  task automatic test_back_to_back;
    v_i = 1'b1; inst_i = enc(ADD, 4'd1, 4'd2, 4'd0, 1'b0, '0);
    tick();
    wb_i = 1'b1; wb_rd_name_i = 4'd1; wb_rd_data_i = 32'h77;
    inst_i = enc(ADD, 4'd3, 4'd1, 4'd0, 1'b0, '0);
    #1;
    total++;
    if (stall_o !== 1'b1) $display("FAIL b2b_stall: got %b want 1", stall_o);
    else passed++;
    tick();
    wb_i = 1'b0;
    total++;
    if ({v_o, wb_o} !== 2'b00) $display("FAIL b2b_bubble: got %b want 00", {v_o, wb_o});
    else passed++;
    #1;
    total++;
    if (stall_o !== 1'b0) $display("FAIL b2b_release: got %b want 0", stall_o);
    else passed++;
    tick();
    total++;
    if ({v_o, wb_rd_name_o, src_o} !== {1'b1, 4'd3, 32'h77})
      $display("FAIL b2b_issue: got v=%b rd=%0d src=%h want 1/3/77", v_o, wb_rd_name_o, src_o);
    else passed++;
    v_i = 1'b0; tick();
  endtask

  task automatic test_wb_same_cycle;
    wb_i = 1'b1; wb_rd_name_i = 4'd4; wb_rd_data_i = 32'h1234;
    v_i = 1'b1; inst_i = enc(ADD, 4'd5, 4'd4, 4'd0, 1'b0, '0);
    #1;
`ifdef WB_BYPASS_EN
    total++;
    if (stall_o !== 1'b0) $display("FAIL wbfw_stall: got %b want 0", stall_o);
    else passed++;
    tick();
    wb_i = 1'b0;
`else
    total++;
    if (stall_o !== 1'b1) $display("FAIL wbfw_stall: got %b want 1", stall_o);
    else passed++;
    tick();
    wb_i = 1'b0;
    total++;
    if (v_o !== 1'b0) $display("FAIL wbfw_bubble: got %b want 0", v_o);
    else passed++;
    tick();
`endif
    total++;
    if ({v_o, src_o} !== {1'b1, 32'h1234})
      $display("FAIL wbfw_issue: got v=%b src=%h want 1/1234", v_o, src_o);
    else passed++;
    v_i = 1'b0; tick();
  endtask

  task automatic test_branch;
    v_i = 1'b1; inst_i = enc(ADD, 4'd6, 4'd2, 4'd0, 1'b0, '0);
    tick();
    inst_i = enc(SUB, 4'd7, 4'd6, 4'd0, 1'b0, '0);
    #1;
    total++;
    if (stall_o !== 1'b1) $display("FAIL br_interlock: got %b want 1", stall_o);
    else passed++;
    branch_i = 1'b1;
    #1;
    total++;
    if (stall_o !== 1'b0) $display("FAIL br_stall: got %b want 0", stall_o);
    else passed++;
    tick();
    total++;
    if ({v_o, wb_o} !== 2'b00) $display("FAIL br_flush: got %b want 00", {v_o, wb_o});
    else passed++;
    branch_i = 1'b0; v_i = 1'b0;
    tick();
    total++;
    if (v_o !== 1'b0) $display("FAIL br_dropped: got %b want 0", v_o);
    else passed++;
  endtask

  task automatic test_stall;
    v_i = 1'b1; inst_i = enc(ADD, 4'd1, 4'd2, 4'd0, 1'b0, '0); addr_i = 32'h200;
    tick();
    total++;
    if ({src_o, dest_o} !== {32'd5, 32'h77})
      $display("FAIL stall_pre: got src=%h dest=%h want 5/77", src_o, dest_o);
    else passed++;
    stall_i = 1'b1; inst_i = enc(MUL, 4'd12, 4'd13, 4'd0, 1'b0, '0); addr_i = 32'h300;
    wb_i = 1'b1; wb_rd_name_i = 4'd8; wb_rd_data_i = 32'hBEEF;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (stall_o !== 1'b1) $display("FAIL stall_out_%0d: got %b want 1", c, stall_o);
      else passed++;
      tick();
      wb_i = 1'b0;
      total++;
      if ({v_o, wb_o, opc_o, origaddr_o, src_o, dest_o} !== {1'b1, 1'b1, 4'd0, 32'h200, 32'd5, 32'h77})
        $display("FAIL stall_hold_%0d: got v=%b opc=%h addr=%h src=%h want 1/0/200/5", c, v_o, opc_o, origaddr_o, src_o);
      else passed++;
    end
    stall_i = 1'b0; inst_i = enc(ADD, 4'd9, 4'd8, 4'd0, 1'b0, '0); addr_i = 32'h304;
    #1;
    total++;
    if (stall_o !== 1'b0) $display("FAIL stall_release: got %b want 0", stall_o);
    else passed++;
    tick();
    total++;
    if ({v_o, src_o, origaddr_o} !== {1'b1, 32'hBEEF, 32'h304})
      $display("FAIL stall_wb_landed: got v=%b src=%h addr=%h want 1/beef/304", v_o, src_o, origaddr_o);
    else passed++;
    v_i = 1'b0; tick();
  endtask

  task automatic test_reset_mid;
    v_i = 1'b1; inst_i = enc(ADD, 4'd1, 4'd2, 4'd0, 1'b0, '0);
    tick();
    inst_i = enc(ADD, 4'd3, 4'd1, 4'd0, 1'b0, '0);
    #1;
    total++;
    if (stall_o !== 1'b1) $display("FAIL rstmid_interlock: got %b want 1", stall_o);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if ({stall_o, v_o, wb_o, src_o, dest_o, wb_rd_name_o, dopc_o, origaddr_o} !== '0)
      $display("FAIL rstmid_clear: stall=%b v=%b wb=%b src=%h dest=%h", stall_o, v_o, wb_o, src_o, dest_o);
    else passed++;
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (stall_o !== 1'b0) $display("FAIL rstmid_nostall: got %b want 0", stall_o);
    else passed++;
    tick();
    total++;
    if ({v_o, wb_rd_name_o, src_o, dest_o} !== {1'b1, 4'd3, 32'd0, 32'd0})
      $display("FAIL rstmid_fresh: got v=%b rd=%0d src=%h dest=%h want 1/3/0/0", v_o, wb_rd_name_o, src_o, dest_o);
    else passed++;
    v_i = 1'b0; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    write_reg(4'd1, 32'd3);
    write_reg(4'd2, 32'd5);
    test_add();
    test_classes();
    test_imm();
    test_back_to_back();
    test_wb_same_cycle();
    test_branch();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; rst  in  1  asynchronous active-low reset.
REQ-002 SHALL have IF ports: v_i  in  1  instruction valid; inst_i  in  `WORD  instruction; addr_i  in  `ADDR  instruction address; stall_o  out  1  hold IF.
REQ-003 SHALL have EX-control ports: stall_i  in  1  EX halted; branch_i  in  1  taken branch/flush.
REQ-004 SHALL have EX writeback ports: wb_i  in  1  write enable; wb_rd_name_i  in  `W_RD  target register; wb_rd_data_i  in  `WORD  write data.
REQ-005 SHALL have EX issue ports, all registered: v_o 1; src_o, dest_o `WORD; wb_o 1; wb_rd_name_o `W_RD; dopc_o `W_DOPC one-hot class; opc_o `W_OPC; origaddr_o `ADDR; cc_o `W_CC.

Function
REQ-006 SHALL decode inst_i into opc, rd, rs, cc, imm-flag and imm fields at bit positions fixed in params.vh.
REQ-007 SHALL drive exactly one dopc_o bit per valid opcode; unknown opcode issues with dopc_o = 0 and wb_o = 0 (NOP).
REQ-008 SHALL set src_o = sign-extended imm when imm-flag = 1, else regfile[rs]; dest_o = regfile[rd]; origaddr_o = addr_i.
REQ-009 SHALL set wb_o = 1 only for ADDSUB, MUL, DIV, ABS, SHIFT, LOGIC, SET, LOAD classes.
REQ-010 SHALL issue with latency 1: fields accepted at edge N appear on outputs after edge N.
REQ-011 SHALL assert load-use interlock when v_o = 1, wb_o = 1 and wb_rd_name_o equals a register read by the current instruction (rs if not immediate, rd).
REQ-012 During interlock SHALL drive stall_o = 1, register v_o = 0 (bubble), and keep the IF instruction held.
REQ-013 SHALL write regfile[wb_rd_name_i] <= wb_rd_data_i on any edge with wb_i = 1, independent of stall_i and branch_i.
REQ-014 When stall_i = 1, SHALL freeze all issue registers, drive stall_o = 1, and ignore v_i.
REQ-015 When branch_i = 1 and stall_i = 0, SHALL register v_o = 0 and discard the current IF instruction; branch_i overrides interlock.
REQ-016 stall_o SHALL be combinational: stall_i OR interlock OR (REQ-020 stall).
REQ-017 v_o SHALL be 0 whenever v_i = 0 at the accepting edge; other issue fields then don't-care but SHALL NOT cause regfile writes in EX.

Reset
REQ-018 On rst low SHALL asynchronously clear v_o, wb_o, src_o, dest_o, wb_rd_name_o, dopc_o, opc_o, origaddr_o, cc_o and all registers to 0; stall_o = 0 while in reset.
REQ-019 Reset mid-interlock or mid-halt SHALL abandon the held instruction; first issue after release is a fresh fetch.

Configuration
REQ-020 With WB_BYPASS_EN defined, regfile reads SHALL return wb_rd_data_i when wb_i = 1 and names match (write-through); without it, SHALL additionally interlock one cycle on that match.

Structure
REQ-021 params.vh SHALL hold instruction field positions, opcode encodings, DOPC bit indices and widths `WORD, `ADDR, `W_RD, `W_OPC, `W_DOPC, `W_CC.
REQ-022 Register file SHALL be a sub-module regfile: 2^`W_RD x `WORD, two async read ports, one sync write port, async reset to 0.

Verification
REQ-023 ADD r1,r2 (r2 = 5, r1 = 3) with v_i = 1 -> next cycle v_o = 1, dopc_o ADDSUB bit, src_o = 5, dest_o = 3, wb_o = 1, wb_rd_name_o = 1.
REQ-024 Back-to-back ADD r1,.. then ADD r3,r1 -> one bubble (v_o = 0), stall_o = 1 one cycle, second issues with updated r1.
REQ-025 wb_i = 1, name 4, data 0x1234, same cycle read r4 -> src_o = 0x1234 with WB_BYPASS_EN; without it, one extra bubble then 0x1234.
REQ-026 branch_i = 1 during interlock -> v_o = 0 next cycle, stall_o = 0, held instruction dropped.
REQ-027 stall_i = 1 for 3 cycles -> outputs unchanged, stall_o = 1; wb_i write during freeze still lands in regfile.
REQ-028 rst low mid-stream -> all outputs 0 immediately; first instruction after release issues after 1 cycle.
